// File: rtl/mips_pipe_pkg.sv
// Shared types for the MIPS pipeline hazard controller: scoreboard entry,
// FSM states, forwarding-select encoding and the source-match helpers.
package mips_pipe_pkg;

   localparam int REG_AW = 5;

   typedef enum logic [1:0] {
      FWD_REG   = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_WB    = 2'd2
   } fwd_sel_t;

   typedef enum logic {
      HZ_RUN      = 1'b0,
      HZ_MEM_WAIT = 1'b1
   } hz_state_t;

   typedef struct packed {
      logic [REG_AW-1:0] dest;
      logic              wb_en;
      logic              mem_read;
      logic [REG_AW-1:0] src1;
      logic [REG_AW-1:0] src2;
   } sb_entry_t;

   // r0 is hard-wired zero, so it never creates a dependency.
   function automatic logic src_match(sb_entry_t e, logic [REG_AW-1:0] src);
      return e.wb_en && (e.dest == src) && (src != '0);
   endfunction

   function automatic fwd_sel_t fwd_pick(sb_entry_t mem_e, sb_entry_t wb_e,
                                         logic [REG_AW-1:0] src);
      if (src_match(mem_e, src)) return FWD_EXMEM;
      if (src_match(wb_e, src))  return FWD_WB;
      return FWD_REG;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage hazard inputs and pipeline control outputs of pipeline_hazard_ctrl.
// The pipeline side uses the master modport, the controller the slave modport.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
   import mips_pipe_pkg::*;

   logic              id_valid;
   logic [REG_AW-1:0] id_src1;
   logic [REG_AW-1:0] id_src2;
   logic              id_uses_src2;
   logic [REG_AW-1:0] id_dest;
   logic              id_wb_en;
   logic              id_mem_read;
   logic              br_taken;
   logic              mem_busy;

   logic              pc_freeze;
   logic              ifid_freeze;
   logic              ifid_flush;
   logic              idex_bubble;
   logic              pipe_freeze;
   fwd_sel_t          fwd_sel_a;
   fwd_sel_t          fwd_sel_b;
   logic [CNT_W-1:0]  stall_count;

   modport master (
      output id_valid, id_src1, id_src2, id_uses_src2, id_dest, id_wb_en,
             id_mem_read, br_taken, mem_busy,
      input  pc_freeze, ifid_freeze, ifid_flush, idex_bubble, pipe_freeze,
             fwd_sel_a, fwd_sel_b, stall_count
   );

   modport slave (
      input  id_valid, id_src1, id_src2, id_uses_src2, id_dest, id_wb_en,
             id_mem_read, br_taken, mem_busy,
      output pc_freeze, ifid_freeze, ifid_flush, idex_bubble, pipe_freeze,
             fwd_sel_a, fwd_sel_b, stall_count
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// hazard_scoreboard: EX/MEM/WB shadow of in-flight destinations plus RAW match
// logic. FORWARDING_EN selects load-use-only stalls and EX forwarding selects.
module hazard_scoreboard
   import mips_pipe_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      advance,
   input  logic      insert_bubble,
   input  logic      id_valid,
   input  sb_entry_t id_entry,
   output logic      raw_hit,
   output fwd_sel_t  fwd_sel_a,
   output fwd_sel_t  fwd_sel_b
);

   localparam int EX  = 0;
   localparam int MEM = 1;
   localparam int WB  = 2;

   sb_entry_t  sb_reg [3];
   logic [2:0] hit1;
   logic [2:0] hit2;
   logic       unused_bits;

   // id_entry.src2 arrives already zeroed when src2 is not read.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_match
         assign hit1[gi] = src_match(sb_reg[gi], id_entry.src1);
         assign hit2[gi] = src_match(sb_reg[gi], id_entry.src2);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) sb_reg[i] <= '0;
      end else if (advance) begin
         sb_reg[EX]  <= (insert_bubble || !id_valid) ? '0 : id_entry;
         sb_reg[MEM] <= sb_reg[EX];
         sb_reg[WB]  <= sb_reg[MEM];
      end
   end

`ifdef FORWARDING_EN
   // Only a load still in EX cannot be bypassed in time.
   assign raw_hit   = id_valid && sb_reg[EX].mem_read && (hit1[EX] || hit2[EX]);
   assign fwd_sel_a = fwd_pick(sb_reg[MEM], sb_reg[WB], sb_reg[EX].src1);
   assign fwd_sel_b = fwd_pick(sb_reg[MEM], sb_reg[WB], sb_reg[EX].src2);
`else
   // No register-file write-through: a WB producer still blocks the reader.
   assign raw_hit   = id_valid && ((|hit1) || (|hit2));
   assign fwd_sel_a = FWD_REG;
   assign fwd_sel_b = FWD_REG;
`endif

   assign unused_bits = ^{hit1, hit2,
                          sb_reg[EX].src1,  sb_reg[EX].src2,  sb_reg[EX].mem_read,
                          sb_reg[MEM].src1, sb_reg[MEM].src2, sb_reg[MEM].mem_read,
                          sb_reg[WB].src1,  sb_reg[WB].src2,  sb_reg[WB].mem_read};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipe: RUN/MEM_WAIT FSM,
// flush/stall priority and stall counter. Macro FORWARDING_EN enables bypassing.
module pipeline_hazard_ctrl
   import mips_pipe_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input logic                   clk,
   input logic                   rst,
   pipeline_hazard_ctrl_if.slave hz
);

   hz_state_t        state_reg;
   logic             br_pend_reg;
   logic [CNT_W-1:0] stall_cnt_reg;

   sb_entry_t id_entry;
   logic      raw_hit;
   fwd_sel_t  sb_fwd_a;
   fwd_sel_t  sb_fwd_b;
   logic      frozen;
   logic      flush;
   logic      stall;

   always_comb begin
      id_entry          = '0;
      id_entry.dest     = hz.id_dest;
      id_entry.wb_en    = hz.id_wb_en;
      id_entry.mem_read = hz.id_mem_read;
      id_entry.src1     = hz.id_src1;
      id_entry.src2     = hz.id_uses_src2 ? hz.id_src2 : '0;
   end

   // A branch that resolved while memory stalled is replayed on the exit cycle.
   always_comb begin
      frozen = 1'b0;
      flush  = 1'b0;
      stall  = 1'b0;
      if (!rst) begin
         if (hz.mem_busy)
            frozen = 1'b1;
         else if (hz.br_taken || (state_reg == HZ_MEM_WAIT && br_pend_reg))
            flush = 1'b1;
         else
            stall = raw_hit;
      end
   end

   hazard_scoreboard u_scoreboard (
      .clk           (clk),
      .rst           (rst),
      .advance       (!frozen),
      .insert_bubble (flush || stall),
      .id_valid      (hz.id_valid),
      .id_entry      (id_entry),
      .raw_hit       (raw_hit),
      .fwd_sel_a     (sb_fwd_a),
      .fwd_sel_b     (sb_fwd_b)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= HZ_RUN;
         br_pend_reg   <= 1'b0;
         stall_cnt_reg <= '0;
      end else begin
         case (state_reg)
            HZ_RUN:      if (hz.mem_busy)  state_reg <= HZ_MEM_WAIT;
            HZ_MEM_WAIT: if (!hz.mem_busy) state_reg <= HZ_RUN;
            default:     state_reg <= HZ_RUN;
         endcase
         if (hz.mem_busy && hz.br_taken)
            br_pend_reg <= 1'b1;
         else if (flush)
            br_pend_reg <= 1'b0;
         if ((frozen || stall || flush) && (stall_cnt_reg != '1))
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
   end

   assign hz.pc_freeze   = stall;
   assign hz.ifid_freeze = stall;
   assign hz.ifid_flush  = flush;
   assign hz.idex_bubble = flush || stall;
   assign hz.pipe_freeze = frozen;
   assign hz.fwd_sel_a   = (rst || frozen) ? FWD_REG : sb_fwd_a;
   assign hz.fwd_sel_b   = (rst || frozen) ? FWD_REG : sb_fwd_b;
   assign hz.stall_count = rst ? '0 : stall_cnt_reg;

endmodule
